gsu_icache_fill_ctrl: RTL

- Instruction-cache controller; drives the write side of the 512-byte negedge instruction SRAM and the fetch-side reads from it.
- Maps fetch addresses against the Cache Base Register (CBR) and tracks 32 line-valid bits, one per 16-byte line.
- On a miss, fills the whole line from the ROM/RAM bus. Out-of-window fetches bypass the cache.
- Sits between the GSU fetch unit and the memory bus arbiter.

---
 rtl/gsu_icache_pkg.sv | 19 +
 rtl/gsu_icache_valid_bits.sv | 29 ++
 rtl/gsu_icache_fill_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/gsu_icache_pkg.sv
// Shared constants and FSM state type for the GSU instruction-cache controller.
package gsu_icache_pkg;

    localparam int LINE_BYTES  = 16;
    localparam int NUM_LINES   = 32;
    localparam int CACHE_BYTES = LINE_BYTES * NUM_LINES;
    localparam int OFF_W       = 4;
    localparam int LINE_W      = 5;
    localparam int SRAM_AW     = OFF_W + LINE_W;

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        HIT_RET,
        FILL,
        BYPASS
    } state_e;

endpackage

// File: rtl/gsu_icache_valid_bits.sv
// Per-line valid vector: set one line by index, clear all, read one line by index.
module gsu_icache_valid_bits #(
    parameter int N_LINES = 32,
    parameter int IDX_W   = $clog2(N_LINES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_all,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_val
);

    logic [N_LINES-1:0] valid_q;

    // Clear-all wins over a coincident set so a base change never leaves a stale line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            valid_q <= '0;
        else if (clr_all)
            valid_q <= '0;
        else if (set_en)
            valid_q[set_idx] <= 1'b1;
    end

    assign rd_val = valid_q[rd_idx];

endmodule

// File: rtl/gsu_icache_fill_ctrl.sv
// GSU instruction-cache controller: CBR window mapping, hit/fill/bypass FSM, SRAM write side.
// Optional ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module gsu_icache_fill_ctrl
    import gsu_icache_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        cbr_in,
    input  logic               cbr_load,
    input  logic               fetch_req,
    input  logic [15:0]        fetch_addr,
    output logic               fetch_ready,
    output logic               fetch_valid,
    output logic [7:0]         fetch_data,
    output logic               mem_req,
    output logic [15:0]        mem_addr,
    input  logic               mem_ack,
    input  logic [7:0]         mem_data,
    output logic [SRAM_AW-1:0] sram_address,
    output logic [7:0]         sram_write_data,
    output logic               sram_write_enable,
    input  logic [7:0]         sram_read_data
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count
`endif
);

    state_e             state_q, state_d;
    logic [15:OFF_W]    cbr_q;
    logic [15:0]        addr_q;
    logic [SRAM_AW-1:0] off_q;
    logic [OFF_W-1:0]   idx_q;
    logic               gap_q;
    logic               kill_q;
    logic [7:0]         ret_q;

    logic [15:0]        off;
    logic               in_win;
    logic               line_valid;
    logic               accept;
    logic               fill_done;
    logic               unused_cbr_low;

    assign unused_cbr_low = ^cbr_in[OFF_W-1:0];

    assign off         = fetch_addr - {cbr_q, {OFF_W{1'b0}}};
    assign in_win      = (off[15:SRAM_AW] == '0);
    assign fetch_ready = (state_q == IDLE) && !fetch_valid;
    assign accept      = fetch_req && fetch_ready;
    assign fill_done   = (state_q == FILL) && gap_q && (idx_q == '1);

    gsu_icache_valid_bits #(.N_LINES(NUM_LINES)) u_valid (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_all (cbr_load),
        .set_en  (fill_done && !kill_q),
        .set_idx (off_q[SRAM_AW-1:OFF_W]),
        .rd_idx  (off[SRAM_AW-1:OFF_W]),
        .rd_val  (line_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Fill alternates request and write cycles (gap_q); the line base is the fetch address
    // with its low nibble replaced, so the bus address can never carry out of the line.
    always_comb begin
        state_d           = state_q;
        mem_req           = 1'b0;
        mem_addr          = '0;
        sram_write_enable = 1'b0;
        sram_address      = off_q;
        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = !in_win ? BYPASS : (line_valid ? HIT : FILL);
            end
            HIT:     state_d = HIT_RET;
            HIT_RET: state_d = IDLE;
            FILL: begin
                sram_address = {off_q[SRAM_AW-1:OFF_W], idx_q};
                if (gap_q) begin
                    sram_write_enable = 1'b1;
                    if (idx_q == '1)
                        state_d = IDLE;
                end else begin
                    mem_req  = 1'b1;
                    mem_addr = {addr_q[15:OFF_W], idx_q};
                end
            end
            BYPASS: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cbr_q           <= '0;
            addr_q          <= '0;
            off_q           <= '0;
            idx_q           <= '0;
            gap_q           <= 1'b0;
            kill_q          <= 1'b0;
            ret_q           <= '0;
            sram_write_data <= '0;
            fetch_valid     <= 1'b0;
            fetch_data      <= '0;
        end else begin
            fetch_valid <= 1'b0;
            if (cbr_load)
                cbr_q <= cbr_in[15:OFF_W];
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q <= fetch_addr;
                        off_q  <= off[SRAM_AW-1:0];
                        idx_q  <= '0;
                        gap_q  <= 1'b0;
                        kill_q <= cbr_load;
                    end
                end
                HIT_RET: begin
                    fetch_valid <= 1'b1;
                    fetch_data  <= sram_read_data;
                end
                FILL: begin
                    if (cbr_load)
                        kill_q <= 1'b1;
                    if (gap_q) begin
                        gap_q <= 1'b0;
                        if (idx_q == '1) begin
                            fetch_valid <= 1'b1;
                            fetch_data  <= ret_q;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (mem_ack) begin
                        gap_q           <= 1'b1;
                        sram_write_data <= mem_data;
                        if (idx_q == off_q[OFF_W-1:0])
                            ret_q <= mem_data;
                    end
                end
                BYPASS: begin
                    if (mem_ack) begin
                        fetch_valid <= 1'b1;
                        fetch_data  <= mem_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (cbr_load) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept && in_win) begin
            if (line_valid && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            else if (!line_valid && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule
